// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared states, 7-seg patterns and digit indices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_SEG_0     = 7'b1000000;
  localparam logic [6:0] c_SEG_1     = 7'b1111001;
  localparam logic [6:0] c_SEG_2     = 7'b0100100;
  localparam logic [6:0] c_SEG_3     = 7'b0110000;
  localparam logic [6:0] c_SEG_4     = 7'b0011001;
  localparam logic [6:0] c_SEG_5     = 7'b0010010;
  localparam logic [6:0] c_SEG_6     = 7'b0000010;
  localparam logic [6:0] c_SEG_7     = 7'b1111000;
  localparam logic [6:0] c_SEG_8     = 7'b0000000;
  localparam logic [6:0] c_SEG_9     = 7'b0010000;
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  localparam int c_IDX_C1  = 0;
  localparam int c_IDX_C10 = 1;
  localparam int c_IDX_S1  = 2;
  localparam int c_IDX_S10 = 3;
  localparam int c_IDX_M1  = 4;
  localparam int c_IDX_M10 = 5;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return c_SEG_0;
      4'd1:    return c_SEG_1;
      4'd2:    return c_SEG_2;
      4'd3:    return c_SEG_3;
      4'd4:    return c_SEG_4;
      4'd5:    return c_SEG_5;
      4'd6:    return c_SEG_6;
      4'd7:    return c_SEG_7;
      4'd8:    return c_SEG_8;
      4'd9:    return c_SEG_9;
      default: return c_SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_mod_digit.sv
// ---------------------------------------------------------------------------
// bcd_mod_digit : one modulo-MOD BCD digit with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_mod_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else if (clr) begin
      q_q <= 4'd0;
    end else if (inc) begin
      // >= keeps any stray out-of-range value from escaping the BCD range
      q_q <= (q_q >= 4'(MOD - 1)) ? 4'd0 : q_q + 4'd1;
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == 4'(MOD - 1));

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl : MM:SS.cc stopwatch with lap freeze and 6-digit 7-seg scan
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN  = 59,
  parameter int N_DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_cs,
  input  logic                tick_scan,
  input  logic                btn_ss,
  input  logic                btn_lap,
  input  logic                btn_clr,
  output logic [23:0]         time_bcd,
  output logic                running,
  output logic                lap_active,
  output logic                wrap,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an
);

  state_t state_q, state_d;
  logic [23:0]         lap_q;
  logic [2:0]          idx_q, idx_d;
  logic                running_q, lap_active_q, wrap_q, dp_q;
  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] an_q;

  logic        w_adv, w_clear, w_lap_load, w_min_max, w_roll;
  logic        w_c0, w_c1, w_c2, w_c3, w_c4, w_c5;
  logic [23:0] w_cnt, w_disp;
  logic [3:0]  w_digit;

  assign w_adv     = tick_cs & ((state_q == ST_RUN) || (state_q == ST_LAP));
  assign w_min_max = ((int'(w_cnt[23:20]) * 10 + int'(w_cnt[19:16])) == MAX_MIN);
  // Minutes roll to 00 on the MAX_MIN compare rather than on digit moduli
  assign w_roll    = (w_c3 & w_min_max) | w_c5;

  bcd_mod_digit #(.MOD(10)) u_c1 (.clk(clk), .rst(rst), .clr(w_clear), .inc(w_adv),
                                  .q(w_cnt[3:0]),   .carry(w_c0));
  bcd_mod_digit #(.MOD(10)) u_c10 (.clk(clk), .rst(rst), .clr(w_clear), .inc(w_c0),
                                   .q(w_cnt[7:4]),   .carry(w_c1));
  bcd_mod_digit #(.MOD(10)) u_s1 (.clk(clk), .rst(rst), .clr(w_clear), .inc(w_c1),
                                  .q(w_cnt[11:8]),  .carry(w_c2));
  bcd_mod_digit #(.MOD(6)) u_s10 (.clk(clk), .rst(rst), .clr(w_clear), .inc(w_c2),
                                  .q(w_cnt[15:12]), .carry(w_c3));
  bcd_mod_digit #(.MOD(10)) u_m1 (.clk(clk), .rst(rst), .clr(w_clear | w_roll),
                                  .inc(w_c3 & ~w_min_max),
                                  .q(w_cnt[19:16]), .carry(w_c4));
  bcd_mod_digit #(.MOD(MAX_MIN / 10 + 1)) u_m10 (.clk(clk), .rst(rst), .clr(w_clear | w_roll),
                                                 .inc(w_c4),
                                                 .q(w_cnt[23:20]), .carry(w_c5));

  always_comb begin
    state_d    = state_q;
    w_clear    = 1'b0;
    w_lap_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_ss) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_ss) begin
          state_d = ST_PAUSE;
        end else if (btn_lap) begin
          state_d    = ST_LAP;
          w_lap_load = 1'b1;
        end
      end
      ST_LAP: begin
        if (btn_ss)       state_d = ST_PAUSE;
        else if (btn_lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (btn_clr) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
        end else if (btn_ss) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (tick_scan) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  end

  assign w_disp  = (state_q == ST_LAP) ? lap_q : w_cnt;
  assign w_digit = w_disp[{idx_d, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lap_q        <= 24'd0;
      idx_q        <= 3'd0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      an_q         <= {{(N_DIGITS-1){1'b1}}, 1'b0};
      seg_q        <= c_SEG_0;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      if (w_lap_load) lap_q <= w_cnt;
      idx_q        <= idx_d;
      running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_active_q <= (state_d == ST_LAP);
      wrap_q       <= w_roll;
      an_q         <= ~(N_DIGITS'(1) << idx_d);
      seg_q        <= seg_decode(w_digit);
      dp_q         <= !((idx_d == 3'(c_IDX_S1)) || (idx_d == 3'(c_IDX_M1)));
    end
  end

  assign time_bcd   = w_cnt;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed + random checks against a centisecond model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  // Small minute limit keeps the full wrap reachable in a short run
  localparam int MAX_MIN = 2;
  localparam int TOTAL   = (MAX_MIN + 1) * 6000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic tick_cs = 1'b0, tick_scan = 1'b0, btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [23:0] time_bcd;
  logic        running, lap_active, wrap, dp;
  logic [6:0]  seg;
  logic [5:0]  an;

  int checks = 0, failures = 0;
  int m_state, m_cnt, m_lap, m_idx;
  logic m_wrap, m_dp;
  logic [6:0] m_seg;
  logic [5:0] m_an;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .N_DIGITS(6)) dut (
    .clk(clk), .rst(rst), .tick_cs(tick_cs), .tick_scan(tick_scan),
    .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .time_bcd(time_bcd), .running(running), .lap_active(lap_active), .wrap(wrap),
    .seg(seg), .dp(dp), .an(an)
  );

  function automatic int dig(int v, int i);
    int cs = v % 100;
    int s  = (v / 100) % 60;
    int m  = v / 6000;
    case (i)
      0:       return cs % 10;
      1:       return cs / 10;
      2:       return s % 10;
      3:       return s / 10;
      4:       return m % 10;
      default: return m / 10;
    endcase
  endfunction

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'(dig(v, i));
    return r;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_lap = 0; m_idx = 0; m_wrap = 1'b0;
    m_an = 6'b111110; m_seg = seg_of(0); m_dp = 1'b1;
  endtask

  task automatic model_step(input bit tcs, input bit ss, input bit lp, input bit clr, input bit sc);
    int disp;
    int pre;
    disp = (m_state == M_LAP) ? m_lap : m_cnt;
    pre  = m_cnt;
    m_wrap = 1'b0;
    if (tcs && (m_state == M_RUN || m_state == M_LAP)) begin
      m_cnt++;
      if (m_cnt == TOTAL) begin m_cnt = 0; m_wrap = 1'b1; end
    end
    case (m_state)
      M_IDLE:  if (ss) m_state = M_RUN;
      M_RUN:   if (ss) m_state = M_PAUSE; else if (lp) begin m_state = M_LAP; m_lap = pre; end
      M_LAP:   if (ss) m_state = M_PAUSE; else if (lp) m_state = M_RUN;
      default: if (clr) begin m_state = M_IDLE; m_cnt = 0; end else if (ss) m_state = M_RUN;
    endcase
    if (sc) m_idx = (m_idx + 1) % 6;
    m_an  = 6'h3f ^ (6'd1 << m_idx);
    m_seg = seg_of(dig(disp, m_idx));
    m_dp  = !(m_idx == 2 || m_idx == 4);
  endtask

  task automatic check_model(input string tag);
    check({tag, "/time"}, time_bcd, to_bcd(m_cnt));
    check({tag, "/running"}, running, (m_state == M_RUN || m_state == M_LAP));
    check({tag, "/lap"}, lap_active, (m_state == M_LAP));
    check({tag, "/wrap"}, wrap, m_wrap);
    check({tag, "/an"}, an, m_an);
    check({tag, "/seg"}, seg, m_seg);
    check({tag, "/dp"}, dp, m_dp);
  endtask

  task automatic cycle(input bit tcs, input bit ss, input bit lp, input bit clr,
                       input bit sc, input bit chk);
    tick_cs = tcs; btn_ss = ss; btn_lap = lp; btn_clr = clr; tick_scan = sc;
    model_step(tcs, ss, lp, clr, sc);
    @(posedge clk); #1;
    tick_cs = 0; btn_ss = 0; btn_lap = 0; btn_clr = 0; tick_scan = 0;
    if (chk) check_model("step");
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/time"}, time_bcd, 24'h000000);
    check({tag, "/running"}, running, 1'b0);
    check({tag, "/lap"}, lap_active, 1'b0);
    check({tag, "/wrap"}, wrap, 1'b0);
    check({tag, "/an"}, an, 6'b111110);
    check({tag, "/seg"}, seg, 7'b1000000);
    check({tag, "/dp"}, dp, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_reset_values("reset");
    rst = 1'b0;

    // 1: start and count one second
    cycle(0, 1, 0, 0, 0, 1);
    repeat (100) cycle(1, 0, 0, 0, 0, 1);
    check("t1_time", time_bcd, 24'h000100);
    check("t1_running", running, 1'b1);
    cycle(0, 0, 0, 1, 0, 1);
    check("clr_in_run", {running, time_bcd}, {1'b1, 24'h000100});

    // 2: run to the last count (02:59.99 with MAX_MIN=2) and wrap
    repeat (TOTAL - 1 - 100) cycle(1, 0, 0, 0, 0, 0);
    check_model("t2_pre");
    check("t2_pre_time", time_bcd, 24'h025999);
    cycle(1, 0, 0, 0, 0, 1);
    check("t2_wrap_time", time_bcd, 24'h000000);
    check("t2_wrap_pulse", wrap, 1'b1);
    cycle(0, 0, 0, 0, 0, 1);
    check("t2_wrap_single", wrap, 1'b0);

    // 3: lap freeze at 00:00.05 while the live count continues
    repeat (5) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    repeat (20) cycle(1, 0, 0, 0, 0, 1);
    check("t3_lap_active", lap_active, 1'b1);
    check("t3_live_time", time_bcd, 24'h000025);
    for (int k = 0; k < 6 && m_idx != 0; k++) cycle(0, 0, 0, 0, 1, 1);
    check("t3_lap_c1", seg, seg_of(5));
    cycle(0, 0, 0, 0, 1, 1);
    check("t3_lap_c10", seg, seg_of(0));
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("t3_live_c10", seg, seg_of(2));
    check("t3_lap_off", lap_active, 1'b0);

    // 4: start/stop coinciding with a tick at 00:00.09
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    repeat (9) cycle(1, 0, 0, 0, 0, 1);
    check("t4_pre", time_bcd, 24'h000009);
    cycle(1, 1, 0, 0, 0, 1);
    check("t4_time", time_bcd, 24'h000010);
    check("t4_paused", running, 1'b0);
    repeat (3) cycle(1, 0, 0, 0, 0, 1);
    check("t4_hold", time_bcd, 24'h000010);

    // 5: clear beats start/stop in PAUSE
    cycle(0, 1, 0, 1, 0, 1);
    check("t5_time", time_bcd, 24'h000000);
    check("t5_running", running, 1'b0);
    cycle(0, 1, 0, 0, 0, 1);

    // 6: scan sequence over two full rounds
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 0, 1, 1);
      check("t6_an", an, 6'h3f ^ (6'd1 << ((k + 1) % 6)));
      check("t6_dp", dp, !(((k + 1) % 6) == 2 || ((k + 1) % 6) == 4));
    end

    // Random mix of ticks and buttons
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1);
    end

    // Asynchronous reset in the middle of a run
    do_reset();
    cycle(0, 1, 0, 0, 0, 1);
    repeat (37) cycle(1, 0, 0, 0, 1, 1);
    check("pre_rst_running", running, 1'b1);
    rst = 1'b1;
    #2;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_model("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
